// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: one SRAM-like port shared by IF and data requesters; round-robin if ARB_ROUND_ROBIN_EN is defined, else data-first.
// Latency: zero cycles on both paths (request mux/addr_ok and data_ok steering are combinational).
// Backpressure: grant is held until mem_addr_ok; mem_req drops while MAX_OUTSTANDING responses are pending.
module sram_port_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic        busy,
  output logic        resp_err
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  logic [CW-1:0]              count;
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [MAX_OUTSTANDING-1:0] order_q;
  logic                       lock;
  logic                       lock_id;

  logic grant_data;
  logic full;
  logic empty;
  logic handshake;
  logic pop;
  logic head_id;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;
`endif

  assign full  = (count == CW'(MAX_OUTSTANDING));
  assign empty = (count == '0);

  // A stalled request keeps its grant so the downstream sees stable fields.
  always_comb begin
    grant_data = GRANT_INST;
    if (lock) begin
      grant_data = lock_id;
    end else if (data_req && !inst_req) begin
      grant_data = GRANT_DATA;
    end else if (data_req && inst_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_data = ~last_grant;
`else
      grant_data = GRANT_DATA;
`endif
    end
  end

  assign mem_req   = (inst_req | data_req) & ~full & ~reset;
  assign mem_wr    = grant_data ? data_wr    : inst_wr;
  assign mem_size  = grant_data ? data_size  : inst_size;
  assign mem_wstrb = grant_data ? data_wstrb : inst_wstrb;
  assign mem_addr  = grant_data ? data_addr  : inst_addr;
  assign mem_wdata = grant_data ? data_wdata : inst_wdata;

  assign handshake    = mem_req & mem_addr_ok;
  assign inst_addr_ok = handshake & (grant_data == GRANT_INST);
  assign data_addr_ok = handshake & (grant_data == GRANT_DATA);

  assign head_id      = order_q[rd_ptr];
  assign pop          = mem_data_ok & ~empty & ~reset;
  assign inst_data_ok = pop & (head_id == GRANT_INST);
  assign data_data_ok = pop & (head_id == GRANT_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign busy = ~empty & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      order_q  <= '0;
      lock     <= 1'b0;
      lock_id  <= GRANT_INST;
      resp_err <= 1'b0;
    end else begin
      if (handshake) begin
        order_q[wr_ptr] <= grant_data;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({handshake, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (handshake) begin
        lock <= 1'b0;
      end else if (mem_req) begin
        lock    <= 1'b1;
        lock_id <= grant_data;
      end
      // A response nobody asked for means the downstream lost sync with us.
      if (mem_data_ok && empty) begin
        resp_err <= 1'b1;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= GRANT_INST;
    end else if (handshake) begin
      last_grant <= grant_data;
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter: requester/memory models drive the DUT,
// a scoreboard queue holds expected responses and a negedge monitor checks them.
module tb_sram_port_arbiter;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0, inst_wr = 1'b0;
  logic [1:0]  inst_size = '0;
  logic [3:0]  inst_wstrb = '0;
  logic [31:0] inst_addr = '0, inst_wdata = '0;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = '0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        busy, resp_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] memq[$];
  logic        resp_legit = 1'b0;
  logic        pend_v = 1'b0, pend_id = 1'b0, last_id = 1'b0, err_exp = 1'b0;
  logic        inst_acc = 1'b0, data_acc = 1'b0;
  int          cnt_start = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .busy(busy), .resp_err(resp_err)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [70:0] req_fields(input logic id);
    if (id) return {data_wr, data_size, data_wstrb, data_addr, data_wdata};
    return {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
  endfunction

  // Response monitor: every legitimate memory response must reach the oldest issuer.
  always @(negedge clk) begin
    exp_t e;
    if (resp_legit) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow at %0t: response with no expected entry", $time);
      end else begin
        e = expq.pop_front();
        chk("data_ok_route", {inst_data_ok, data_data_ok}, e.id ? 2'b01 : 2'b10);
        chk("inst_rdata", inst_rdata, e.data);
        chk("data_rdata", data_rdata, e.data);
      end
    end else begin
      chk("no_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    end
  end

  task automatic step(input int p_req, input int p_aok, input int p_dok, input bit force_dok);
    logic        win;
    logic        exp_req;
    logic [31:0] d;
    @(posedge clk); #1;
    if (inst_acc) begin inst_req = 1'b0; inst_acc = 1'b0; end
    if (data_acc) begin data_req = 1'b0; data_acc = 1'b0; end
    if (!inst_req && int'($urandom_range(99)) < p_req) begin
      inst_req   = 1'b1;
      inst_wr    = 1'($urandom_range(1));
      inst_size  = 2'($urandom_range(3));
      inst_wstrb = 4'($urandom_range(15));
      inst_addr  = $urandom;
      inst_wdata = $urandom;
    end
    if (!data_req && int'($urandom_range(99)) < p_req) begin
      data_req   = 1'b1;
      data_wr    = 1'($urandom_range(1));
      data_size  = 2'($urandom_range(3));
      data_wstrb = 4'($urandom_range(15));
      data_addr  = $urandom;
      data_wdata = $urandom;
    end
    mem_addr_ok = (int'($urandom_range(99)) < p_aok);
    cnt_start   = expq.size();
    resp_legit  = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = $urandom;
    if (memq.size() > 0) begin
      if (int'($urandom_range(99)) < p_dok) begin
        mem_data_ok = 1'b1;
        mem_rdata   = memq.pop_front();
        resp_legit  = 1'b1;
      end
    end else if (force_dok) begin
      mem_data_ok = 1'b1;
    end

    @(negedge clk);
    exp_req = (inst_req || data_req) && (cnt_start < MAXO);
    chk("mem_req", mem_req, exp_req);
    chk("busy", busy, cnt_start != 0);
    chk("resp_err", resp_err, err_exp);
    if (pend_v) win = pend_id;
    else if (inst_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      win = ~last_id;
`else
      win = 1'b1;
`endif
    end else win = data_req;
    if (exp_req) chk("mem_fields", {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}, req_fields(win));
    chk("inst_addr_ok", inst_addr_ok, exp_req && mem_addr_ok && !win);
    chk("data_addr_ok", data_addr_ok, exp_req && mem_addr_ok && win);
    if (exp_req && mem_addr_ok) begin
      d = $urandom;
      expq.push_back('{win, d});
      memq.push_back(d);
      last_id = win;
      pend_v  = 1'b0;
      if (win) data_acc = 1'b1;
      else inst_acc = 1'b1;
    end else if (exp_req) begin
      pend_v  = 1'b1;
      pend_id = win;
    end
    if (mem_data_ok && cnt_start == 0) err_exp = 1'b1;
  endtask

  task automatic reset_phase(input int n);
    @(posedge clk); #1;
    reset = 1'b1;
    inst_req = 1'b1; data_req = 1'b1;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; resp_legit = 1'b0;
    expq.delete(); memq.delete();
    pend_v = 1'b0; last_id = 1'b0; err_exp = 1'b0;
    inst_acc = 1'b0; data_acc = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
      chk("rst_resp_err", resp_err, 1'b0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    inst_req = 1'b0; data_req = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    while ((expq.size() > 0 || inst_req || data_req) && k < bound) begin
      step(0, 100, 100, 1'b0);
      k++;
    end
    if (k >= bound) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d responses still expected after %0d cycles", expq.size(), bound);
    end
  endtask

  initial begin
    reset_phase(3);
    repeat (300) step(60, 60, 50, 1'b0);
    repeat (30)  step(90, 90, 0, 1'b0);
    repeat (300) step(80, 80, 90, 1'b0);
    repeat (300) step(50, 30, 30, 1'b0);
    repeat (200) step(100, 100, 100, 1'b0);
    drain(200);
    step(0, 0, 0, 1'b1);
    repeat (4) step(0, 0, 0, 1'b0);
    repeat (10) step(90, 90, 0, 1'b0);
    reset_phase(2);
    repeat (300) step(70, 70, 60, 1'b0);
    drain(200);
    repeat (2) step(0, 0, 0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one SRAM-like memory port between the instruction-fetch requester (IF) and the data requester (EX/MEM) of the pipeline. The block grants one request per cycle and locks the grant until the address handshake completes. It records the issue order of accepted transactions in an order FIFO and steers each returning `data_ok`/`rdata` back to the requester that issued it. It sits between the core's `inst_sram_*`/`data_sram_*` interfaces and the single downstream memory port (bridge/cache).

## Interface
- `MAX_OUTSTANDING`, 4: order-FIFO depth = max accepted-but-unanswered transactions; power of 2, ≥2.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `inst_req` in 1 / `inst_wr` in 1 / `inst_size` in 2 / `inst_wstrb` in 4 / `inst_addr` in 32 / `inst_wdata` in 32: IF request, held until `inst_addr_ok`.
- `inst_addr_ok` out 1 / `inst_data_ok` out 1 / `inst_rdata` out 32: IF responses.
- `data_req` in 1 / `data_wr` in 1 / `data_size` in 2 / `data_wstrb` in 4 / `data_addr` in 32 / `data_wdata` in 32: data request, held until `data_addr_ok`.
- `data_addr_ok` out 1 / `data_data_ok` out 1 / `data_rdata` out 32: data responses.
- `mem_req` out 1 / `mem_wr` out 1 / `mem_size` out 2 / `mem_wstrb` out 4 / `mem_addr` out 32 / `mem_wdata` out 32: shared downstream request.
- `mem_addr_ok` in 1 / `mem_data_ok` in 1 / `mem_rdata` in 32: downstream responses.
- `busy` out 1: FIFO count ≠ 0.
- `resp_err` out 1: sticky; set when `mem_data_ok` arrives with the FIFO empty.

## Operation
- Grant: `grant_data` selects the request fields muxed onto `mem_*`.
  - If `lock` is set, use `lock_id`.
  - Otherwise, if only one requester is active, grant it.
  - If both are active, apply the arbitration policy (see Configuration).
- `mem_req` = (`inst_req` | `data_req`) & ~full & ~reset.
- `*_addr_ok` = `mem_addr_ok` & `mem_req` & granted-to-that-requester. The non-granted requester's `addr_ok` is 0.
- Lock:
  - Set, with `lock_id` = current grant, when `mem_req` & ~`mem_addr_ok`.
  - Cleared on the handshake cycle (`mem_req` & `mem_addr_ok`).
  - A locked grant never switches, even if a higher-priority requester arrives.
- Push: on handshake, push requester id (0 = inst, 1 = data) into the order FIFO. `last_grant` ← id.
- Pop: on `mem_data_ok` with FIFO non-empty, pop the head.
  - Assert `inst_data_ok` or `data_data_ok` for the head id, same cycle.
  - `inst_rdata` = `data_rdata` = `mem_rdata` (unconditional passthrough).
- Writes also return `data_ok` and occupy a FIFO entry.
- Full (count = `MAX_OUTSTANDING`): `mem_req` = 0, and both `addr_ok` = 0.
  - An existing `lock` is kept.
  - A pop in the same cycle does not reopen the port that cycle; `full` is registered count-based.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Empty-FIFO `mem_data_ok`: no `data_ok` to either requester, no pointer change, `resp_err` ← 1.
- Count width: clog2(`MAX_OUTSTANDING`)+1. Pointers are clog2(`MAX_OUTSTANDING`) bits and wrap naturally.
- Cancels/flushes are requester-side (discard of the next `data_ok`). The arbiter always delivers every response in order.

## Timing
- Reset values:
  - count = 0, pointers = 0, `lock` = 0, `lock_id` = 0, `last_grant` = 0 (inst), `resp_err` = 0.
  - While reset is high: `mem_req`, all `addr_ok`, all `data_ok`, `busy` = 0.
- Request path is zero-latency combinational: requester → `mem_*`, and `mem_addr_ok` → `*_addr_ok`.
- Response path is zero-latency: `mem_data_ok` → `*_data_ok` in the same cycle.
- Throughput: one handshake and one response per cycle, sustained.
- Reset asserted mid-transaction: all state is cleared immediately and outstanding responses are forgotten. The downstream port must be reset together with this block.

## Configuration
- `ARB_ROUND_ROBIN_EN`:
  - Defined: when both requesters are active and the port is unlocked, grant the requester ≠ `last_grant`.
  - Undefined: data has fixed priority over inst, and `last_grant` is unused.

## Test plan
- Single inst read at 0x1c000000, `mem_addr_ok` same cycle, `mem_data_ok` 3 cycles later with 0x02c00000 → `inst_addr_ok` in cycle 0, `inst_data_ok`=1 with `inst_rdata`=0x02c00000 in cycle 3, `data_data_ok`=0 throughout.
- Both requesting, `mem_addr_ok` held 0 for 2 cycles, then 1 → `mem_addr` stays at the first-granted address (data addr, fixed priority) all 3 cycles; only `data_addr_ok` pulses.
- Interleaved order inst, data, inst with responses R1, R2, R3 → `data_ok` pulses route inst, data, inst in order; `busy` drops after R3.
- `MAX_OUTSTANDING`=4, 4 handshakes with no response → `mem_req`=0 despite active requests; one `mem_data_ok` → `mem_req` re-asserts the next cycle.
- `mem_data_ok` while empty → no `*_data_ok`, `resp_err`=1 and stays 1 until reset.
- With `ARB_ROUND_ROBIN_EN`, both requests continuously held, `mem_addr_ok`=1 → grants alternate data, inst, data, inst starting from data after reset.
